uart_cmd_host: RTL and testbench

Byte-level command interpreter on the user side of the `uart` FIFO interface. It pops received bytes, decodes a 2- or 3-byte command frame, performs one register write or read on a simple internal register bus, and pushes a one-byte reply into the TX FIFO. It is the host-facing control endpoint for on-chip registers over the serial link.

---
 rtl/uart_cmd_pkg.sv | 32 +++
 rtl/uart_cmd_host_if.sv | 31 +++
 rtl/uart_cmd_timer.sv | 35 +++
 rtl/uart_cmd_host.sv | 174 +++++++++++++++++
 tb/tb_uart_cmd_host.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants and types for the UART command host.
//   CMD_WR / CMD_RD   : frame command bytes ('W', 'R')
//   RSP_ACK / RSP_ERR : reply bytes ('K', '?')
//   cmd_state_t       : command interpreter state encoding
//   sat_inc8          : saturating 8-bit increment
//   is_frame_state    : true in the states that wait for frame payload bytes
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StDoWr,
        StDoRd,
        StRdWait,
        StSend
    } cmd_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'h01;
    endfunction

    function automatic logic is_frame_state(input cmd_state_t s);
        return (s == StGetAddr) || (s == StGetData);
    endfunction

endpackage

// File: rtl/uart_cmd_host_if.sv
// uart_cmd_host_if: bundles the UART FIFO side and the register bus of the
// command host.
//   RX FIFO : rx_empty, r_data (to host); rd_uart (from host)
//   TX FIFO : tx_full (to host); w_data, wr_uart (from host)
//   Reg bus : reg_addr, reg_wdata, reg_wr, reg_rd (from host); reg_rdata (to host)
// master = command host, slave = FIFOs plus register file.
interface uart_cmd_host_if;

    logic       rx_empty;
    logic [7:0] r_data;
    logic       rd_uart;
    logic       tx_full;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;

    modport master (
        input  rx_empty, r_data, tx_full, reg_rdata,
        output rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_wr, reg_rd
    );

    modport slave (
        output rx_empty, r_data, tx_full, reg_rdata,
        input  rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_wr, reg_rd
    );

endinterface

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer: inter-byte timeout counter.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : synchronous clear (wins over en)
//   en       : count enable
//   expired  : high while the count equals TIMEOUT-1
// TO_BIT must be wide enough that 2^TO_BIT > TIMEOUT.
module uart_cmd_timer #(
    parameter int unsigned TIMEOUT = 1_000_000,
    parameter int unsigned TO_BIT  = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_BIT-1:0] LastCnt = TO_BIT'(TIMEOUT - 1);
    localparam logic [TO_BIT-1:0] OneCnt  = {{(TO_BIT-1){1'b0}}, 1'b1};

    logic [TO_BIT-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + OneCnt;
        end
    end

    assign expired = (cnt_q == LastCnt);

endmodule

// File: rtl/uart_cmd_host.sv
// uart_cmd_host: byte-level command interpreter between the UART FIFOs and a
// simple register bus.
//   Frames: 'W' addr data -> register write, reply 'K'
//           'R' addr      -> register read, reply is the read byte
//           other         -> reply '?', err_cnt++
//   A frame stalled mid-way for TIMEOUT cycles is dropped silently with err_cnt++.
// Ports:
//   clk, rst : clock, asynchronous active-low reset
//   bus      : uart_cmd_host_if.master (RX/TX FIFO and register bus)
//   busy     : high in every state except idle
//   err_cnt  : saturating protocol error count
// All outputs are registered.
module uart_cmd_host
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1_000_000,
    parameter int unsigned TO_BIT  = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_cmd_host_if.master        bus,
    output logic                   busy,
    output logic [7:0]             err_cnt
);

    cmd_state_t state_q;
    logic       is_write_q;
    logic [7:0] reply_q;
    logic       rd_uart_q;
    logic       wr_uart_q;
    logic [7:0] w_data_q;
    logic [7:0] reg_addr_q;
    logic [7:0] reg_wdata_q;
    logic       reg_wr_q;
    logic       reg_rd_q;
    logic       busy_q;
    logic [7:0] err_cnt_q;

    logic in_frame;
    logic byte_ok;
    logic to_clr;
    logic to_expired;

    assign in_frame = is_frame_state(state_q);

    // While the previous pop is still in flight the FIFO head is stale, so a
    // byte is only taken when no pop was issued in the previous cycle.
    assign byte_ok = !bus.rx_empty && !rd_uart_q;

    // Every entry into a frame state and every accepted byte coincides with a
    // pop cycle, so rd_uart_q doubles as the timer restart.
    assign to_clr = !in_frame || rd_uart_q;

    uart_cmd_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_BIT  (TO_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (to_clr),
        .en      (in_frame),
        .expired (to_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            is_write_q  <= 1'b0;
            reply_q     <= 8'h00;
            rd_uart_q   <= 1'b0;
            wr_uart_q   <= 1'b0;
            w_data_q    <= 8'h00;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            rd_uart_q <= 1'b0;
            wr_uart_q <= 1'b0;
            reg_wr_q  <= 1'b0;
            reg_rd_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (byte_ok) begin
                        rd_uart_q <= 1'b1;
                        busy_q    <= 1'b1;
                        if (bus.r_data == CMD_WR) begin
                            is_write_q <= 1'b1;
                            state_q    <= StGetAddr;
                        end else if (bus.r_data == CMD_RD) begin
                            is_write_q <= 1'b0;
                            state_q    <= StGetAddr;
                        end else begin
                            reply_q   <= RSP_ERR;
                            err_cnt_q <= sat_inc8(err_cnt_q);
                            state_q   <= StSend;
                        end
                    end
                end

                StGetAddr: begin
                    if (byte_ok) begin
                        rd_uart_q  <= 1'b1;
                        reg_addr_q <= bus.r_data;
                        state_q    <= is_write_q ? StGetData : StDoRd;
                    end else if (to_expired) begin
                        err_cnt_q <= sat_inc8(err_cnt_q);
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end
                end

                StGetData: begin
                    if (byte_ok) begin
                        rd_uart_q   <= 1'b1;
                        reg_wdata_q <= bus.r_data;
                        state_q     <= StDoWr;
                    end else if (to_expired) begin
                        err_cnt_q <= sat_inc8(err_cnt_q);
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end
                end

                StDoWr: begin
                    reg_wr_q <= 1'b1;
                    reply_q  <= RSP_ACK;
                    state_q  <= StSend;
                end

                StDoRd: begin
                    reg_rd_q <= 1'b1;
                    state_q  <= StRdWait;
                end

                StRdWait: begin
                    // reg_rdata is valid the cycle after the strobe is visible.
                    if (!reg_rd_q) begin
                        reply_q <= bus.reg_rdata;
                        state_q <= StSend;
                    end
                end

                StSend: begin
                    if (!bus.tx_full) begin
                        wr_uart_q <= 1'b1;
                        w_data_q  <= reply_q;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.rd_uart   = rd_uart_q;
    assign bus.wr_uart   = wr_uart_q;
    assign bus.w_data    = w_data_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_wr    = reg_wr_q;
    assign bus.reg_rd    = reg_rd_q;
    assign busy          = busy_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_host.sv
// Bench for uart_cmd_host: behavioural RX/TX FIFOs and a 256x8 register file
// around the DUT, with a frame-level reference model feeding a scoreboard.
module tb_uart_cmd_host;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    uart_cmd_host_if bus ();

    uart_cmd_host #(
        .TIMEOUT (100),
        .TO_BIT  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  mem[256];
    logic [7:0]  ref_mem[256];
    int          ref_err = 0;
    bit          force_full = 1'b0;
    bit          rand_full = 1'b0;
    bit          rd_pend = 1'b0;
    logic [7:0]  rd_pend_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s: actual=%0h required=none at %0t", name, act, $time);
    endtask

    // FIFO / register-file environment plus the scoreboard monitor.
    initial begin
        bus.rx_empty  = 1'b1;
        bus.r_data    = 8'h00;
        bus.tx_full   = 1'b0;
        bus.reg_rdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.wr_uart) begin
                if (bus.tx_full) flag("push_while_full", bus.w_data);
                if (exp_tx.size() == 0) flag("tx_unexpected", bus.w_data);
                else check("tx_byte", bus.w_data, exp_tx.pop_front());
            end
            if (bus.reg_wr) begin
                if (exp_wr.size() == 0) flag("wr_unexpected", {bus.reg_addr, bus.reg_wdata});
                else check("reg_write", {bus.reg_addr, bus.reg_wdata}, exp_wr.pop_front());
                mem[bus.reg_addr] = bus.reg_wdata;
            end
            // Read data is valid only in the cycle after the strobe.
            if (rd_pend) begin
                bus.reg_rdata = mem[rd_pend_addr];
                rd_pend = 1'b0;
            end else begin
                bus.reg_rdata = 8'($urandom_range(0, 255));
            end
            if (bus.reg_rd) begin
                if (exp_rd.size() == 0) flag("rd_unexpected", bus.reg_addr);
                else check("reg_read_addr", bus.reg_addr, exp_rd.pop_front());
                rd_pend = 1'b1;
                rd_pend_addr = bus.reg_addr;
            end
            if (bus.rd_uart) begin
                if (rx_q.size() == 0) flag("pop_empty_fifo", 0);
                else void'(rx_q.pop_front());
            end
            bus.rx_empty = (rx_q.size() == 0);
            bus.r_data = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
            bus.tx_full = force_full | (rand_full & ($urandom_range(0, 3) == 0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic issue_write(input logic [7:0] a, input logic [7:0] d);
        rx_q.push_back(8'h57);
        rx_q.push_back(a);
        rx_q.push_back(d);
        ref_mem[a] = d;
        exp_wr.push_back({a, d});
        exp_tx.push_back(8'h4B);
    endtask

    task automatic issue_read(input logic [7:0] a);
        rx_q.push_back(8'h52);
        rx_q.push_back(a);
        exp_rd.push_back(a);
        exp_tx.push_back(ref_mem[a]);
    endtask

    task automatic issue_bad(input logic [7:0] b);
        rx_q.push_back(b);
        exp_tx.push_back(8'h3F);
        if (ref_err < 255) ref_err++;
    endtask

    task automatic issue_random_bad();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == 8'h57 || b == 8'h52);
        issue_bad(b);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (n < budget && !(rx_q.size() == 0 && exp_tx.size() == 0 && exp_wr.size() == 0
                               && exp_rd.size() == 0 && !busy && !rd_pend)) begin
            cyc(1);
            n++;
        end
        if (n >= budget) begin
            flag(name, {8'(rx_q.size()), 8'(exp_tx.size()), 8'(exp_wr.size()), 8'(exp_rd.size())});
            exp_tx.delete();
            exp_wr.delete();
            exp_rd.delete();
        end
        check({name, "_err_cnt"}, err_cnt, 32'(ref_err));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rd_uart"}, bus.rd_uart, 0);
        check({name, "_wr_uart"}, bus.wr_uart, 0);
        check({name, "_reg_wr"}, bus.reg_wr, 0);
        check({name, "_reg_rd"}, bus.reg_rd, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_w_data"}, bus.w_data, 0);
        check({name, "_reg_addr"}, bus.reg_addr, 0);
        check({name, "_reg_wdata"}, bus.reg_wdata, 0);
        check({name, "_err_cnt"}, err_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        cyc(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        cyc(2);

        // Write, read back, bad command then read.
        issue_write(8'h10, 8'hA5);
        wait_idle("write", 200);
        issue_read(8'h10);
        wait_idle("read", 200);
        issue_bad(8'h41);
        issue_read(8'h10);
        wait_idle("bad_cmd", 200);

        // Timeout after a partial write frame: no access, no reply.
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h10);
        cyc(60);
        check("timeout_not_early", busy, 1);
        cyc(90);
        if (ref_err < 255) ref_err++;
        check("timeout_idle", busy, 0);
        check("timeout_err", err_cnt, 32'(ref_err));
        issue_bad(8'hA5);
        wait_idle("after_timeout", 200);

        // Backpressure on the reply.
        force_full = 1'b1;
        issue_read(8'h10);
        cyc(10);
        for (int i = 0; i < 50; i++) begin
            check("bp_no_push", bus.wr_uart, 0);
            check("bp_busy", busy, 1);
            cyc(1);
        end
        force_full = 1'b0;
        cyc(2);
        check("bp_push_on_release", bus.wr_uart, 1);
        wait_idle("backpressure", 200);

        // Random frames in batches with random TX backpressure.
        rand_full = 1'b1;
        for (int b = 0; b < 10; b++) begin
            for (int f = 0; f < 4; f++) begin
                logic [7:0] a;
                int k;
                a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
                k = $urandom_range(0, 4);
                if (k < 2) issue_write(a, 8'($urandom_range(0, 255)));
                else if (k < 4) issue_read(a);
                else issue_random_bad();
            end
            wait_idle("random", 2000);
        end

        // Error counter saturation.
        for (int b = 0; b < 13; b++) begin
            for (int f = 0; f < 20; f++) issue_random_bad();
            wait_idle("saturate", 2000);
        end
        check("err_saturated", err_cnt, 255);
        rand_full = 1'b0;

        // Reset mid-frame: leftover byte is parsed afresh as a command.
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h20);
        rx_q.push_back(8'h20);
        begin
            int n = 0;
            while (rx_q.size() > 1 && n < 100) begin
                cyc(1);
                n++;
            end
            if (n >= 100) flag("midframe_consume", rx_q.size());
        end
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        cyc(2);
        check_reset_outputs("midreset_hold");
        ref_err = 0;
        rst = 1'b1;
        exp_tx.push_back(8'h3F);
        ref_err = 1;
        wait_idle("leftover", 200);
        cyc(20);
        issue_write(8'h20, 8'h33);
        issue_read(8'h20);
        wait_idle("after_reset", 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
